// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the reg_file block.
package reg_file_pkg;
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = 4;
endpackage

// File: rtl/reg_file_if.sv
// Access bus for reg_file: one write port, two read ports, status.
interface reg_file_if import reg_file_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd0_addr;
  logic [DATA_W-1:0] rd0_data;
  logic [ADDR_W-1:0] rd1_addr;
  logic [DATA_W-1:0] rd1_data;
  logic              ready;
  logic              err;

  modport master (
    output wr_en, wr_addr, wr_data, rd0_addr, rd1_addr,
    input  rd0_data, rd1_data, ready, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd0_addr, rd1_addr,
    output rd0_data, rd1_data, ready, err
  );
endinterface

// File: rtl/reg_file_clr.sv
// Clear sequencer: walks an index over every register after reset, one
// per cycle, then switches to RUN. ready is a registered copy of RUN.
module reg_file_clr import reg_file_pkg::*; #(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output state_t            state,
  output logic [ADDR_W-1:0] idx,
  output logic              ready
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  // State/index advance; leaves CLEAR on the edge that zeroes the last entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      idx   <= '0;
      ready <= 1'b0;
    end else if (state == CLEAR) begin
      if (idx == LAST) begin
        state <= RUN;
        ready <= 1'b1;
        idx   <= '0;
      end else begin
        idx <= idx + ADDR_W'(1);
      end
    end
  end
endmodule

// File: rtl/reg_file.sv
// Register file, one write port and two registered read ports.
// Contents are zeroed one entry per cycle after reset (see reg_file_clr).
// Out-of-range accesses are dropped/read as zero and flagged on err.
// Optional feature: define REG_FILE_BYPASS_EN to forward same-cycle write
// data to a read of the same address; otherwise the read sees old data.
module reg_file import reg_file_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] clr_idx;
  logic              ready_q;

  reg_file_clr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_clr (
    .clk   (clk),
    .rst   (rst),
    .state (state),
    .idx   (clr_idx),
    .ready (ready_q)
  );

  assign bus.ready = ready_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              run, wr_ok, rd0_ok, rd1_ok, wr_fire, oor;
  logic [DATA_W-1:0] rd0_nxt, rd1_nxt;

  assign run     = (state == RUN);
  assign wr_ok   = {1'b0, bus.wr_addr}  < DEPTH_X;
  assign rd0_ok  = {1'b0, bus.rd0_addr} < DEPTH_X;
  assign rd1_ok  = {1'b0, bus.rd1_addr} < DEPTH_X;
  assign wr_fire = run & bus.wr_en & wr_ok;
  // Any offender in the cycle collapses into one err pulse.
  assign oor     = run & ((bus.wr_en & ~wr_ok) | ~rd0_ok | ~rd1_ok);

  // Next read data: array lookup, zero when out of range, optional forward.
  always_comb begin
    rd0_nxt = '0;
    rd1_nxt = '0;
    if (rd0_ok) rd0_nxt = mem[bus.rd0_addr];
    if (rd1_ok) rd1_nxt = mem[bus.rd1_addr];
`ifdef REG_FILE_BYPASS_EN
    if (wr_fire && (bus.rd0_addr == bus.wr_addr)) rd0_nxt = bus.wr_data;
    if (wr_fire && (bus.rd1_addr == bus.wr_addr)) rd1_nxt = bus.wr_data;
`else
`endif
  end

  // Storage: clear walk during CLEAR, bus writes during RUN, nothing under rst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        mem[clr_idx] <= '0;
      else if (wr_fire)
        mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Registered read ports and error pulse; all forced to zero outside RUN.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      bus.rd0_data <= '0;
      bus.rd1_data <= '0;
      bus.err      <= 1'b0;
    end else begin
      bus.rd0_data <= rd0_nxt;
      bus.rd1_data <= rd1_nxt;
      bus.err      <= oor;
    end
  end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, register data width in bits.
REQ-002 SHALL provide parameter DEPTH, default 16, number of registers (2..256).
REQ-003 SHALL provide parameter ADDR_W, default 4, address width; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port wr_en  input  1  write request this cycle.
REQ-007 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-008 SHALL have port wr_data  input  DATA_W  write data.
REQ-009 SHALL have port rd0_addr  input  ADDR_W  read port 0 address.
REQ-010 SHALL have port rd0_data  output  DATA_W  read port 0 data, registered.
REQ-011 SHALL have port rd1_addr  input  ADDR_W  read port 1 address.
REQ-012 SHALL have port rd1_data  output  DATA_W  read port 1 data, registered.
REQ-013 SHALL have port ready  output  1  high when clear sequence done and accesses honoured.
REQ-014 SHALL have port err  output  1  one-cycle pulse on any out-of-range access.

Function
REQ-015 SHALL implement states CLEAR and RUN; rst forces CLEAR with clear index 0.
REQ-016 In CLEAR with rst low, SHALL zero register[index] and increment index once per cycle.
REQ-017 SHALL move CLEAR->RUN in the cycle after index DEPTH-1 is zeroed; clear takes exactly DEPTH cycles after rst falls.
REQ-018 ready SHALL be 0 in CLEAR and 1 in RUN, registered.
REQ-019 In CLEAR, wr_en SHALL be ignored and rd0_data/rd1_data SHALL load 0.
REQ-020 In RUN, wr_en with wr_addr < DEPTH SHALL write wr_data to register[wr_addr] at the clock edge.
REQ-021 In RUN, each read port SHALL load register[rdN_addr] into rdN_data at the clock edge; read latency exactly 1 cycle.
REQ-022 Both read ports SHALL operate independently, including identical addresses.
REQ-023 Address >= DEPTH: write SHALL be dropped; read SHALL load 0; err SHALL be 1 the following cycle.
REQ-024 err SHALL be 0 in CLEAR and in any RUN cycle with no out-of-range access; multiple simultaneous offenders give a single pulse.
REQ-025 Same-cycle write and read of same address: behaviour per REQ-031/REQ-032.
REQ-026 rst asserted mid-RUN or mid-CLEAR SHALL abort the operation, drop any same-cycle write, and restart the full clear sequence.

Reset
REQ-027 On rst, rd0_data, rd1_data, ready, err SHALL be 0 at the next edge.
REQ-028 Register contents SHALL read as 0 only after the clear sequence; no multi-register reset in one cycle.
REQ-029 No asynchronous reset paths SHALL exist.

Configuration
REQ-030 Macro REG_FILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-031 With REG_FILE_BYPASS_EN defined, a read of wr_addr in a cycle with a valid RUN write SHALL return wr_data.
REQ-032 Without it, such a read SHALL return the pre-write contents; new value visible the following read.

Structure
REQ-033 Package reg_file_pkg SHALL hold the CLEAR/RUN state enum and default DATA_W/DEPTH/ADDR_W constants.
REQ-034 Clear sequencer (state, index, ready) SHALL be sub-module reg_file_clr; storage and read ports stay in reg_file.

Verification
REQ-035 rst high 2 cycles then low -> ready 0 for exactly 16 cycles, then 1; all 16 registers read 0x00.
REQ-036 RUN: write 0xA5 to addr 3, next cycle read rd0=3, rd1=3 -> both outputs 0xA5 one cycle later.
REQ-037 RUN: write 0x3C to addr 7 while rd0_addr=7 -> rd0_data 0x3C with REG_FILE_BYPASS_EN, previous value without.
REQ-038 DEPTH=12: write addr 13 with 0xFF, read addr 14 -> err 1 for one cycle, rd0_data 0x00, no register modified.
REQ-039 rst pulsed 1 cycle after writing 0x55 to addr 2 -> ready drops, full 12/16-cycle clear reruns, addr 2 reads 0x00.
REQ-040 Write during CLEAR (wr_en=1, addr 0, 0x11) -> ignored; addr 0 reads 0x00 after ready rises.
